da_sign_par: RTL and testbench



---
 rtl/da_pkg.sv | 21 ++
 rtl/da_lut.sv | 36 +++
 rtl/da_sign_par.sv | 149 ++++++++++++++
 tb/tb_da_sign_par.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared definitions for the bit-serial distributed-arithmetic unit.
//   - da_state_e : control FSM states
//   - da_acc_w   : exact accumulator width for N taps of XW x CW products
//   - da_tab_w   : width of one coefficient-table entry (sum of up to N coefs)
package da_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } da_state_e;

  function automatic int da_tab_w(input int n, input int cw);
    return cw + $clog2(n);
  endfunction

  function automatic int da_acc_w(input int n, input int xw, input int cw);
    return cw + $clog2(n) + xw;
  endfunction

endpackage

// File: rtl/da_lut.sv
// Distributed-arithmetic coefficient table.
// Entry a holds the signed sum of every c_k whose address bit a[k] is set.
// All 2^N entries are constants derived from COEFS at elaboration.
// Ports:
//   addr_i  N-bit address (bit k = current bit-slice of sample k)
//   t_o     TW-bit signed table value
module da_lut #(
  parameter int               N     = 3,
  parameter int               CW    = 4,
  parameter int               TW    = 6,
  parameter logic [N*CW-1:0]  COEFS = '0
) (
  input  logic [N-1:0]         addr_i,
  output logic signed [TW-1:0] t_o
);

  function automatic logic signed [TW-1:0] tab_entry(input int a);
    logic signed [CW-1:0] c;
    logic signed [TW-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++) begin
      c = COEFS[k*CW +: CW];
      if (a[k]) s = s + TW'(c);
    end
    return s;
  endfunction

  logic signed [TW-1:0] tab [2**N];

  for (genvar ga = 0; ga < 2**N; ga++) begin : g_tab
    assign tab[ga] = tab_entry(ga);
  end

  assign t_o = tab[addr_i];

endmodule

// File: rtl/da_sign_par.sv
// Bit-serial distributed-arithmetic sum of products: y = sum_k c_k * x_k.
// Samples are consumed LSB-first, one bit-slice per cycle; the MSB slice is
// subtracted, which makes the result exact for two's-complement inputs.
// Optional feature: define DA_SAT_EN to clamp y to OUT_W bits (sat flags it);
// otherwise y wraps to the low OUT_W bits and sat is 0.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    sample vector handshake (ready only in IDLE)
//   x_in                 N packed signed XW-bit samples
//   out_valid/out_ready  result handshake, result held until taken
//   y, sat               signed result and clamp flag
module da_sign_par
  import da_pkg::*;
#(
  parameter int              N     = 3,
  parameter int              XW    = 4,
  parameter int              CW    = 4,
  parameter logic [N*CW-1:0] COEFS = {4'sd1, 4'sd3, 4'sd2},
  parameter int              OUT_W = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*XW-1:0]         x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat
);

  localparam int TW    = da_tab_w(N, CW);
  localparam int ACC_W = da_acc_w(N, XW, CW);
  localparam int CNT_W = (XW > 1) ? $clog2(XW) : 1;

  da_state_e                state_q, state_d;
  logic [N-1:0][XW-1:0]     x_q, x_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [OUT_W-1:0]  y_q, y_d;
  logic                     sat_q, sat_d;
  logic                     ov_q, ov_d;

  logic [N-1:0]             addr;
  logic signed [TW-1:0]     t;
  logic signed [ACC_W-1:0]  t_sh;
  logic                     last;
  logic signed [OUT_W-1:0]  y_fmt;
  logic                     sat_fmt;

  for (genvar k = 0; k < N; k++) begin : g_addr
    assign addr[k] = x_q[k][0];
  end

  da_lut #(.N(N), .CW(CW), .TW(TW), .COEFS(COEFS)) u_lut (
    .addr_i (addr),
    .t_o    (t)
  );

  // Each slice enters at weight 2^(XW-1) and is halved every later cycle,
  // so slice j ends at weight 2^j with no bits shifted out.
  assign t_sh = $signed(ACC_W'(t)) <<< (XW - 1);
  assign last = (cnt_q == CNT_W'(XW - 1));

  // Result formatting from the final accumulator.
  if (OUT_W >= ACC_W) begin : g_ext
    assign y_fmt   = OUT_W'(acc_q);
    assign sat_fmt = 1'b0;
  end else begin : g_narrow
`ifdef DA_SAT_EN
    logic [ACC_W-OUT_W:0] hi;
    logic                 ovf;
    // In range iff all bits from the output sign bit upward agree.
    assign hi      = acc_q[ACC_W-1:OUT_W-1];
    assign ovf     = !((&hi) || !(|hi));
    assign y_fmt   = !ovf ? acc_q[OUT_W-1:0] :
                     acc_q[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
    assign sat_fmt = ovf;
`else
    assign y_fmt   = acc_q[OUT_W-1:0];
    assign sat_fmt = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    sat_d   = sat_q;
    ov_d    = ov_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = last ? (acc_q >>> 1) - t_sh : (acc_q >>> 1) + t_sh;
        for (int k = 0; k < N; k++) x_d[k] = x_q[k] >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle registers the result; afterwards wait for the taker.
        if (!ov_q) begin
          y_d   = y_fmt;
          sat_d = sat_fmt;
          ov_d  = 1'b1;
        end else if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign y         = y_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_da_sign_par.sv
// Bench for da_sign_par: default unit, a 6-bit-output unit sharing its inputs,
// and a wide N=5/XW=8/CW=6 unit driven with random handshakes.
module tb_da_sign_par;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, out_ready;
  logic [11:0] x_in;
  logic        ir0, ov0, sat0, ir1, ov1, sat1;
  logic signed [9:0] y0;
  logic signed [5:0] y1;

  logic        iv2, ordy2, ir2, ov2, sat2;
  logic [39:0] x2;
  logic signed [16:0] y2;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  da_sign_par u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir0), .x_in(x_in),
    .out_valid(ov0), .out_ready(out_ready), .y(y0), .sat(sat0)
  );

  da_sign_par #(.OUT_W(6)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1), .x_in(x_in),
    .out_valid(ov1), .out_ready(out_ready), .y(y1), .sat(sat1)
  );

  da_sign_par #(
    .N(5), .XW(8), .CW(6),
    .COEFS({6'sd13, -6'sd7, 6'sd31, -6'sd31, 6'sd5}),
    .OUT_W(17)
  ) u2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .x_in(x2),
    .out_valid(ov2), .out_ready(ordy2), .y(y2), .sat(sat2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a vector and return once it has been accepted.
  task automatic send(input int a, input int b, input int c);
    int w;
    logic [3:0] xa, xb, xc;
    xa = 4'(a); xb = 4'(b); xc = 4'(c);
    x_in     = {xc, xb, xa};
    in_valid = 1'b1;
    w = 0;
    while (!ir0 && w < 30) begin tick(); w++; end
    chk("accept_wait", int'(ir0), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ov0 && lat < 20) begin tick(); lat++; end
  endtask

  task automatic xact(input int a, input int b, input int c,
                      input int ey, input int ey6, input int es6);
    int lat;
    out_ready = 1'b1;
    send(a, b, c);
    wait_out(lat);
    chk("latency", lat, 5);
    chk("y", int'(y0), ey);
    chk("sat", int'(sat0), 0);
    chk("y6_valid", int'(ov1), 1);
    chk("y6", int'(y1), ey6);
    chk("sat6", int'(sat1), es6);
    tick();
    chk("pulse", int'(ov0), 0);
  endtask

  initial begin
    int lat;
    int q[$];
    int sent, got, cyc, e;
    int cf[5] = '{5, -31, 31, -7, 13};
    logic signed [7:0] xs;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in = '0;
    iv2 = 1'b0; ordy2 = 1'b0; x2 = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ov", int'(ov0), 0);
    chk("rst_y", int'(y0), 0);
    chk("rst_sat", int'(sat0), 0);
    chk("rst_ir", int'(ir0), 1);

    xact(1, 2, 3, 11, 11, 0);
`ifdef DA_SAT_EN
    xact(-8, -8, -8, -48, -32, 1);
    xact(7, 7, 7, 42, 31, 1);
`else
    xact(-8, -8, -8, -48, 16, 0);
    xact(7, 7, 7, 42, -22, 0);
`endif
    xact(-1, 5, -8, 5, 5, 0);

    // Backpressure: result must hold, new offers must be ignored.
    out_ready = 1'b0;
    send(1, 2, 3);
    wait_out(lat);
    chk("bp_lat", lat, 5);
    for (int i = 0; i < 6; i++) begin
      chk("bp_y", int'(y0), 11);
      chk("bp_ov", int'(ov0), 1);
      chk("bp_ir", int'(ir0), 0);
      in_valid = 1'b1;
      x_in = {4'd7, 4'd7, 4'd7};
      tick();
    end
    in_valid = 1'b0;
    chk("bp_hold", int'(y0), 11);
    out_ready = 1'b1;
    tick();
    chk("bp_taken", int'(ov0), 0);
    chk("bp_idle", int'(ir0), 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bp_no_extra", int'(ov0), 0);
    end

    // Reset during the second RUN cycle discards the in-flight result.
    send(7, 7, 7);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_ov", int'(ov0), 0);
    chk("mid_y", int'(y0), 0);
    chk("mid_ir", int'(ir0), 1);
    reset = 1'b0;
    xact(1, 2, 3, 11, 11, 0);

    // Random traffic on the wide unit against a scoreboard.
    sent = 0; got = 0; cyc = 0;
    while ((sent < 1000 || q.size() > 0) && cyc < 60000) begin
      iv2   = (sent < 1000) && ($urandom_range(0, 3) != 0);
      ordy2 = ($urandom_range(0, 2) != 0);
      e = 0;
      for (int k = 0; k < 5; k++) begin
        xs = 8'($urandom);
        x2[k*8 +: 8] = xs;
        e += int'(xs) * cf[k];
      end
      if (iv2 && ir2) begin
        q.push_back(e);
        sent++;
      end
      if (ov2 && ordy2) begin
        chk("rnd_q", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("rnd_y", int'(y2), q.pop_front());
          chk("rnd_sat", int'(sat2), 0);
        end
        got++;
      end
      tick();
      cyc++;
    end
    iv2 = 1'b0;
    chk("rnd_got", got, 1000);
    chk("rnd_left", q.size(), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rnd_no_extra", int'(ov2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
